// File: rtl/snes_pad_responder.sv
// SNES pad emulator: answers a host's LATCH/PULSE polling with a 16-bit active-low
// serial word built from BUTTONS and fixed ID bits, like a standard pad's shift register.

module snes_pad_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level_r,
    output logic edge_r
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(FILTER_LEN - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0]          cnt_r;
    logic                   sample_s;

    assign sample_s = sync_r[SYNC_STAGES-1];

    // metastability chain for the asynchronous host line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
        end
    end

    // level accepted only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= 1'b0;
            edge_r  <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else begin
            edge_r <= 1'b0;
            if (sample_s == level_r) begin
                cnt_r <= CNT_ZERO;
            end else if (cnt_r == CNT_MAX) begin
                level_r <= sample_s;
                edge_r  <= 1'b1;
                cnt_r   <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end
endmodule

module snes_pad_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 4,
    parameter logic [3:0] ID_BITS     = 4'b0000
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        LATCH,
    input  logic        PULSE,
    input  logic [11:0] BUTTONS,
    output logic        DATA,
    output logic [4:0]  BIT_CNT,
    output logic        FRAME_DONE,
    output logic        POLL_SEEN
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_r;
    logic [15:0] shreg_r;
    logic        data_r;
    logic [4:0]  bit_cnt_r;
    logic        frame_done_r;
    logic        poll_seen_r;

    logic        latch_level_s;
    logic        latch_edge_s;
    logic        pulse_level_s;
    logic        pulse_edge_s;
    logic        latch_rise_s;
    logic        latch_fall_s;
    logic        pulse_rise_s;
    logic [15:0] load_word_s;

    snes_pad_cond #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_latch_cond (
        .clk    (CLOCK),
        .rst_n  (RESET_N),
        .din    (LATCH),
        .level_r(latch_level_s),
        .edge_r (latch_edge_s)
    );

    snes_pad_cond #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_pulse_cond (
        .clk    (CLOCK),
        .rst_n  (RESET_N),
        .din    (PULSE),
        .level_r(pulse_level_s),
        .edge_r (pulse_edge_s)
    );

    assign latch_rise_s = latch_edge_s & latch_level_s;
    assign latch_fall_s = latch_edge_s & ~latch_level_s;
    assign pulse_rise_s = pulse_edge_s & pulse_level_s;
    // line level is inverted: a pressed button or asserted ID bit reads as 0
    assign load_word_s  = ~{ID_BITS, BUTTONS};

    // protocol FSM; a latch rise always wins over any pending shift
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r      <= ST_IDLE;
            shreg_r      <= 16'hFFFF;
            data_r       <= 1'b1;
            bit_cnt_r    <= 5'd0;
            frame_done_r <= 1'b0;
            poll_seen_r  <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            poll_seen_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (latch_rise_s) begin
                        state_r   <= ST_LOAD;
                        shreg_r   <= load_word_s;
                        data_r    <= load_word_s[0];
                        bit_cnt_r <= 5'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    shreg_r   <= load_word_s;
                    data_r    <= load_word_s[0];
                    bit_cnt_r <= 5'd0;
                    if (latch_fall_s) begin
                        state_r     <= ST_SHIFT;
                        poll_seen_r <= 1'b1;
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_SHIFT: begin
                    if (latch_rise_s) begin
                        state_r   <= ST_LOAD;
                        shreg_r   <= load_word_s;
                        data_r    <= load_word_s[0];
                        bit_cnt_r <= 5'd0;
                    end else if (pulse_rise_s) begin
                        shreg_r   <= {1'b0, shreg_r[15:1]};
                        data_r    <= shreg_r[1];
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                        if (bit_cnt_r == 5'd15) begin
                            frame_done_r <= 1'b1;
                            state_r      <= ST_DONE;
                        end else begin
                            state_r <= ST_SHIFT;
                        end
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    // a real pad's serial input is grounded once the word is out
                    data_r <= 1'b0;
                    if (latch_rise_s) begin
                        state_r   <= ST_LOAD;
                        shreg_r   <= load_word_s;
                        data_r    <= load_word_s[0];
                        bit_cnt_r <= 5'd0;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign DATA       = data_r;
    assign BIT_CNT    = bit_cnt_r;
    assign FRAME_DONE = frame_done_r;
    assign POLL_SEEN  = poll_seen_r;
endmodule
